fetch_redirect_ctrl: RTL and testbench

Arbitrates every fetch-redirect source and sequences its delivery into the PC register, between the backend, decode stage, branch predictor and the PC/ICache front end. Three sources compete: backend flush, decode-stage correction and branch-predictor taken. The block picks one per cycle by fixed priority. A prediction that arrives while the PC cannot advance is held until it can. The block also maintains a fetch epoch so that downstream stages can drop responses that were in flight across a flush.

---
 rtl/fetch_redirect_ctrl_pkg.sv | 23 ++
 rtl/fetch_redirect_ctrl_redirect_pick.sv | 46 ++++
 rtl/fetch_redirect_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_redirect_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl_pkg
// Shared types and constants for the fetch-redirect controller:
//   - redir_state_e : controller FSM states (IDLE / HOLD / FLUSH)
//   - REDIR_SRC_*   : 2-bit encoding reported on redir_src_o
//   - EPOCH_W_DEF   : default width of the fetch epoch counter
// ---------------------------------------------------------------------------
package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_FLUSH = 2'd2
  } redir_state_e;

  localparam logic [1:0] REDIR_SRC_NONE = 2'd0;
  localparam logic [1:0] REDIR_SRC_BE   = 2'd1;
  localparam logic [1:0] REDIR_SRC_ID   = 2'd2;
  localparam logic [1:0] REDIR_SRC_BP   = 2'd3;

  localparam int EPOCH_W_DEF = 2;

endpackage

// File: rtl/fetch_redirect_ctrl_redirect_pick.sv
// ---------------------------------------------------------------------------
// redirect_pick
// Combinational fixed-priority selector over the three redirect sources
// (backend > decode > predictor).
// Ports:
//   be_vld_i / be_tgt_i  backend flush request and target
//   id_vld_i / id_tgt_i  decode correction request and target
//   bp_vld_i / bp_tgt_i  predictor taken (already qualified by caller)
//   vld_o                some source is requesting
//   tgt_o                target of the winning source (0 when none)
//   src_o                REDIR_SRC_* code of the winner (NONE when none)
// ---------------------------------------------------------------------------
module redirect_pick
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic        be_vld_i,
  input  logic [31:0] be_tgt_i,
  input  logic        id_vld_i,
  input  logic [31:0] id_tgt_i,
  input  logic        bp_vld_i,
  input  logic [31:0] bp_tgt_i,
  output logic        vld_o,
  output logic [31:0] tgt_o,
  output logic [1:0]  src_o
);

  always_comb begin
    vld_o = 1'b0;
    tgt_o = '0;
    src_o = REDIR_SRC_NONE;
    if (be_vld_i) begin
      vld_o = 1'b1;
      tgt_o = be_tgt_i;
      src_o = REDIR_SRC_BE;
    end else if (id_vld_i) begin
      vld_o = 1'b1;
      tgt_o = id_tgt_i;
      src_o = REDIR_SRC_ID;
    end else if (bp_vld_i) begin
      vld_o = 1'b1;
      tgt_o = bp_tgt_i;
      src_o = REDIR_SRC_BP;
    end
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_redirect_ctrl
// Arbitrates backend flush, decode correction and predictor-taken redirects
// and sequences them into the PC register. Flushes are registered and pulse
// pc_flush_o one cycle later; predictions pass through combinationally when
// the PC can advance, otherwise they are held (HOLD) until it can.
// A fetch epoch advances with every flush pulse so downstream stages can
// discard responses that were in flight across it.
//
// Build option: define FETCH_EPOCH_EN to include the epoch counter; when it
// is undefined fetch_epoch_o is tied to 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   be_flush_i/be_target_i   backend redirect
//   id_redir_i/id_target_i   decode-stage correction
//   bp_taken_i/bp_target_i   branch predictor taken
//   ic_ready_i               ICache accepts a fetch this cycle
//   pause_i                  backend fetch pause
//   pc_flush_o/pc_new_o      registered forced PC update and its target
//   pc_pred_taken_o/_addr_o  prediction redirect to the PC
//   pc_stall_o               = !ic_ready_i
//   fetch_epoch_o            current fetch epoch
//   redir_busy_o             prediction pending (HOLD)
//   redir_src_o              source of the redirect driven this cycle
// ---------------------------------------------------------------------------
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int EPOCH_W = EPOCH_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               be_flush_i,
  input  logic [31:0]        be_target_i,
  input  logic               id_redir_i,
  input  logic [31:0]        id_target_i,
  input  logic               bp_taken_i,
  input  logic [31:0]        bp_target_i,
  input  logic               ic_ready_i,
  input  logic               pause_i,
  output logic               pc_flush_o,
  output logic [31:0]        pc_new_o,
  output logic               pc_pred_taken_o,
  output logic [31:0]        pc_pred_addr_o,
  output logic               pc_stall_o,
  output logic [EPOCH_W-1:0] fetch_epoch_o,
  output logic               redir_busy_o,
  output logic [1:0]         redir_src_o
);

  redir_state_e state_q, state_d;
  logic [31:0]  new_tgt_q, new_tgt_d;
  logic [1:0]   flush_src_q, flush_src_d;
  logic [31:0]  hold_tgt_q, hold_tgt_d;

  logic        pick_vld;
  logic [31:0] pick_tgt;
  logic [1:0]  pick_src;
  logic        bp_qual;
  logic        flush_req;
  logic        advance;
  logic        pred_taken;

  // New predictions are only considered in IDLE: HOLD ignores them and
  // FLUSH (pc_flush_o high) suppresses them.
  assign bp_qual = bp_taken_i && (state_q == ST_IDLE);

  redirect_pick u_pick (
    .be_vld_i (be_flush_i),
    .be_tgt_i (be_target_i),
    .id_vld_i (id_redir_i),
    .id_tgt_i (id_target_i),
    .bp_vld_i (bp_qual),
    .bp_tgt_i (bp_target_i),
    .vld_o    (pick_vld),
    .tgt_o    (pick_tgt),
    .src_o    (pick_src)
  );

  assign flush_req = pick_vld && (pick_src != REDIR_SRC_BP);
  assign advance   = ic_ready_i && !pause_i;

  // A same-cycle flush request always beats a prediction, including a held one.
  always_comb begin
    pred_taken = 1'b0;
    if (!flush_req && advance) begin
      if (state_q == ST_HOLD)
        pred_taken = 1'b1;
      else if (state_q == ST_IDLE && pick_src == REDIR_SRC_BP)
        pred_taken = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    new_tgt_d   = new_tgt_q;
    flush_src_d = flush_src_q;
    hold_tgt_d  = hold_tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (flush_req)
          state_d = ST_FLUSH;
        else if (pick_src == REDIR_SRC_BP && !advance) begin
          state_d    = ST_HOLD;
          hold_tgt_d = pick_tgt;
        end
      end
      ST_HOLD: begin
        if (flush_req)
          state_d = ST_FLUSH;
        else if (advance)
          state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        state_d = flush_req ? ST_FLUSH : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush_req) begin
      new_tgt_d   = pick_tgt;
      flush_src_d = pick_src;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      new_tgt_q   <= '0;
      flush_src_q <= REDIR_SRC_NONE;
      hold_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      new_tgt_q   <= new_tgt_d;
      flush_src_q <= flush_src_d;
      hold_tgt_q  <= hold_tgt_d;
    end
  end

`ifdef FETCH_EPOCH_EN
  logic [EPOCH_W-1:0] epoch_q, epoch_d;

  // Advances in the capture cycle so the new epoch appears with the pulse.
  assign epoch_d = flush_req ? epoch_q + EPOCH_W'(1) : epoch_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) epoch_q <= '0;
    else     epoch_q <= epoch_d;
  end

  assign fetch_epoch_o = epoch_q;
`else
  assign fetch_epoch_o = '0;
`endif

  assign pc_flush_o      = (state_q == ST_FLUSH);
  assign pc_new_o        = new_tgt_q;
  assign pc_pred_taken_o = pred_taken;
  assign pc_pred_addr_o  = !pred_taken ? 32'h0 :
                           (state_q == ST_HOLD) ? hold_tgt_q : pick_tgt;
  assign pc_stall_o      = !ic_ready_i;
  assign redir_busy_o    = (state_q == ST_HOLD);
  assign redir_src_o     = pc_flush_o ? flush_src_q :
                           pred_taken ? REDIR_SRC_BP : REDIR_SRC_NONE;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fetch_redirect_ctrl
// Directed stimulus for fetch_redirect_ctrl. Expected redirect pulses are
// queued as stimulus is issued; a negedge monitor pops and compares each
// pulse the DUT presents. Level checks (reset values, busy, stall, epoch)
// are made directly from the stimulus thread.
// ---------------------------------------------------------------------------
module tb_fetch_redirect_ctrl;
  import fetch_redirect_ctrl_pkg::*;

  localparam int EW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          be_flush_i, id_redir_i, bp_taken_i, ic_ready_i, pause_i;
  logic [31:0]   be_target_i, id_target_i, bp_target_i;
  logic          pc_flush_o, pc_pred_taken_o, pc_stall_o, redir_busy_o;
  logic [31:0]   pc_new_o, pc_pred_addr_o;
  logic [EW-1:0] fetch_epoch_o;
  logic [1:0]    redir_src_o;

  fetch_redirect_ctrl #(.EPOCH_W(EW)) dut (
    .clk             (clk),
    .rst             (rst),
    .be_flush_i      (be_flush_i),
    .be_target_i     (be_target_i),
    .id_redir_i      (id_redir_i),
    .id_target_i     (id_target_i),
    .bp_taken_i      (bp_taken_i),
    .bp_target_i     (bp_target_i),
    .ic_ready_i      (ic_ready_i),
    .pause_i         (pause_i),
    .pc_flush_o      (pc_flush_o),
    .pc_new_o        (pc_new_o),
    .pc_pred_taken_o (pc_pred_taken_o),
    .pc_pred_addr_o  (pc_pred_addr_o),
    .pc_stall_o      (pc_stall_o),
    .fetch_epoch_o   (fetch_epoch_o),
    .redir_busy_o    (redir_busy_o),
    .redir_src_o     (redir_src_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          flush;
    logic [31:0]   addr;
    logic [1:0]    src;
    logic [EW-1:0] ep;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [EW-1:0] ep_model = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    be_flush_i = 1'b0;
    id_redir_i = 1'b0;
    bp_taken_i = 1'b0;
  endtask

  task automatic exp_flush(input logic [31:0] a, input logic [1:0] s);
    exp_t e;
`ifdef FETCH_EPOCH_EN
    ep_model = ep_model + 1'b1;
`endif
    e.flush = 1'b1; e.addr = a; e.src = s; e.ep = ep_model;
    sb.push_back(e);
  endtask

  task automatic exp_pred(input logic [31:0] a);
    exp_t e;
    e.flush = 1'b0; e.addr = a; e.src = REDIR_SRC_BP; e.ep = ep_model;
    sb.push_back(e);
  endtask

  // Monitor: every redirect pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pc_flush_o || pc_pred_taken_o) begin
      exp_t e;
      if (pc_flush_o && pc_pred_taken_o)
        chk("flush_and_pred_exclusive", 32'd1, 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, pc_flush_o, pc_pred_taken_o}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind_flush", {31'd0, pc_flush_o}, {31'd0, e.flush});
        chk("pulse_addr", e.flush ? pc_new_o : pc_pred_addr_o, e.addr);
        chk("pulse_src", {30'd0, redir_src_o}, {30'd0, e.src});
        chk("pulse_epoch", 32'(fetch_epoch_o), 32'(e.ep));
      end
    end
  end

  initial begin
    rst = 1'b1;
    clr();
    be_target_i = '0; id_target_i = '0; bp_target_i = '0;
    ic_ready_i = 1'b0;
    pause_i    = 1'b0;
    #3;
    // Reset values, stall follows ic_ready even in reset.
    chk("rst_flush", {31'd0, pc_flush_o}, 32'd0);
    chk("rst_pred", {31'd0, pc_pred_taken_o}, 32'd0);
    chk("rst_busy", {31'd0, redir_busy_o}, 32'd0);
    chk("rst_src", {30'd0, redir_src_o}, 32'd0);
    chk("rst_epoch", 32'(fetch_epoch_o), 32'd0);
    chk("rst_new", pc_new_o, 32'd0);
    chk("rst_paddr", pc_pred_addr_o, 32'd0);
    chk("rst_stall_hi", {31'd0, pc_stall_o}, 32'd1);
    ic_ready_i = 1'b1;
    #1;
    chk("rst_stall_lo", {31'd0, pc_stall_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step(); step();

    // Backend flush: pulse next cycle, epoch advances.
    chk("epoch_before", 32'(fetch_epoch_o), 32'd0);
    be_flush_i = 1'b1; be_target_i = 32'h1C000100;
    exp_flush(32'h1C000100, REDIR_SRC_BE);
    step(); clr(); step();

    // Unblocked prediction: same-cycle pass-through.
    bp_taken_i = 1'b1; bp_target_i = 32'h1C000040;
    exp_pred(32'h1C000040);
    step(); clr(); step();

    // Blocked prediction held until ready; second bp during HOLD ignored.
    ic_ready_i = 1'b0; bp_taken_i = 1'b1; bp_target_i = 32'h1C000080;
    step();
    chk("hold_busy1", {31'd0, redir_busy_o}, 32'd1);
    chk("hold_stall", {31'd0, pc_stall_o}, 32'd1);
    bp_target_i = 32'h1C000999;
    step();
    chk("hold_busy2", {31'd0, redir_busy_o}, 32'd1);
    clr();
    step();
    chk("hold_busy3", {31'd0, redir_busy_o}, 32'd1);
    exp_pred(32'h1C000080);
    ic_ready_i = 1'b1;
    step();
    chk("hold_release_busy", {31'd0, redir_busy_o}, 32'd0);
    step();

    // All three sources at once: backend wins, no prediction pulse.
    be_flush_i = 1'b1; be_target_i = 32'h1C000200;
    id_redir_i = 1'b1; id_target_i = 32'h1C000300;
    bp_taken_i = 1'b1; bp_target_i = 32'h1C000400;
    exp_flush(32'h1C000200, REDIR_SRC_BE);
    step(); clr(); step();

    // Decode correction alone.
    id_redir_i = 1'b1; id_target_i = 32'h1C000500;
    exp_flush(32'h1C000500, REDIR_SRC_ID);
    step(); clr(); step();

    // Flush arriving during HOLD discards the held prediction.
    ic_ready_i = 1'b0; bp_taken_i = 1'b1; bp_target_i = 32'h1C000600;
    step(); clr();
    chk("hold2_busy", {31'd0, redir_busy_o}, 32'd1);
    ic_ready_i = 1'b1;
    be_flush_i = 1'b1; be_target_i = 32'h1C000700;
    exp_flush(32'h1C000700, REDIR_SRC_BE);
    step(); clr();
    chk("hold2_cleared", {31'd0, redir_busy_o}, 32'd0);
    step(); step();

    // Pause blocks a prediction just like a stall.
    pause_i = 1'b1; bp_taken_i = 1'b1; bp_target_i = 32'h1C000800;
    step(); clr();
    chk("pause_busy", {31'd0, redir_busy_o}, 32'd1);
    exp_pred(32'h1C000800);
    pause_i = 1'b0;
    step(); step();

    // Reset mid-HOLD: immediate clear, no pulse after release.
    ic_ready_i = 1'b0; bp_taken_i = 1'b1; bp_target_i = 32'h1C000900;
    step(); clr();
    chk("rhold_busy", {31'd0, redir_busy_o}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rhold_busy_clr", {31'd0, redir_busy_o}, 32'd0);
    chk("rhold_epoch_clr", 32'(fetch_epoch_o), 32'd0);
    chk("rhold_new_clr", pc_new_o, 32'd0);
    ep_model = '0;
    ic_ready_i = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    step();
    chk("rhold_no_pred", {31'd0, pc_pred_taken_o}, 32'd0);
    step(); step();

    // Four back-to-back flushes under stall+pause: epochs 1,2,3,0.
    ic_ready_i = 1'b0; pause_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      be_flush_i  = 1'b1;
      be_target_i = 32'h1C001000 + 32'(i) * 32'h10;
      exp_flush(be_target_i, REDIR_SRC_BE);
      step();
    end
    clr();
    step();
    chk("epoch_after_four", 32'(fetch_epoch_o), 32'd0);
    chk("flush_done", {31'd0, pc_flush_o}, 32'd0);
    ic_ready_i = 1'b1; pause_i = 1'b0;

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
